fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one `fifo` write port between NUM_REQ producers. It grants the port to one requester at a time for bursts of up to MAX_BURST words, and drives the FIFO's `w_en`/`data_in`. It never writes while the FIFO reports `full`. The block sits directly in front of the `fifo` instance; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    // Arbiter states: IDLE holds no grant, BURST holds exactly one owner.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of every statistics counter.
    localparam int STAT_W = 16;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker. It scans req_i upward from ptr_i, wrapping
// at NUM_REQ, and returns the first active requester as a one-hot vector.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               found_o
);

    // The first hit in scan order wins. Later hits are ignored once found_o is set.
    always_comb begin
        int slot;
        slot    = 0;
        gnt_o   = '0;
        found_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(ptr_i) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!found_o && req_i[slot[PTR_W-1:0]]) begin
                gnt_o[slot[PTR_W-1:0]] = 1'b1;
                found_o                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ producers.
// Each grant lasts for at most MAX_BURST words. The arbiter never writes while
// full_i is high.
// Optional feature: define FIFO_ARB_STATS_EN to add per-requester write counters
// and a stall-cycle counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            ack_o,
    input  logic                          full_i,
    output logic                          w_en_o,
    output logic [DATA_WIDTH-1:0]         data_in_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     wr_count_o,
    output logic [STAT_W-1:0]             stall_count_o
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;

    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   owner_next;
    logic [PTR_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic               owner_active;
    logic               write_en;
    logic               burst_done;

    // The owner only writes while its request is high and the FIFO has room.
    assign owner_active = |(gnt_q & req_i);
    assign write_en     = owner_active & ~full_i;
    assign w_en_o       = write_en;
    assign ack_o        = gnt_q & req_i & {NUM_REQ{~full_i}};
    assign gnt_o        = gnt_q;

    // A burst ends when the owner lets go, or when this write is word MAX_BURST.
    assign burst_done = (state_q == BURST) &&
                        (!owner_active ||
                         (write_en && ((int'(bcnt_q) + 1) == MAX_BURST)));

    // While a burst runs, scan from the slot after the owner so that a handoff
    // re-arbitrates in the same cycle. The old owner is scanned last.
    assign pick_ptr = (state_q == BURST) ? owner_next : ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .found_o (pick_found)
    );

    // Convert the one-hot grant to an index, plus the wrapped index that follows it.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
        if (int'(owner_idx) == NUM_REQ - 1) begin
            owner_next = '0;
        end else begin
            owner_next = owner_idx + PTR_W'(1);
        end
    end

    // Route the owner's data slice to the FIFO. The output is zero when no write occurs.
    always_comb begin
        data_in_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i] && write_en) begin
                data_in_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic for grant, priority pointer and burst counter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BURST;
                    gnt_d   = pick_gnt;
                    bcnt_d  = '0;
                end
            end
            BURST: begin
                if (burst_done) begin
                    ptr_d  = owner_next;
                    bcnt_d = '0;
                    if (pick_found) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (write_en) begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers. Reset drops the grant at once, which also drops w_en and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] wr_cnt_q;
    logic [STAT_W-1:0]         stall_cnt_q;

    assign wr_count_o    = wr_cnt_q;
    assign stall_count_o = stall_cnt_q;

    // Per-requester accepted-write counters wrap. The stall counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_cnt_q[i*STAT_W +: STAT_W] <= wr_cnt_q[i*STAT_W +: STAT_W] +
                                                {{(STAT_W-1){1'b0}}, ack_o[i]};
            end
            if ((state_q == BURST) && full_i && (stall_cnt_q != {STAT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            end
        end
    end
`else
    // This build carries no statistics state.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter using directed scenarios and a
// randomized run. Every run is checked against a transaction-level model of the arbiter.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqData;
    logic           full;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           wEn;
    logic [W-1:0]   dataIn;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] wrCount;
    logic [15:0]     stallCount;
`endif

    logic [W-1:0] prodData [N];
    logic [W-1:0] dutLog [$];

    int checks = 0;
    int errors = 0;

    int           mOwner;
    int           mPtr;
    int           mCnt;
    logic [N-1:0] expGnt;
    logic [N-1:0] expAck;
    logic         expWen;
    logic [W-1:0] expData;

    fifo_wr_arbiter #(
        .DATA_WIDTH (W),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .req_data_i (reqData),
        .gnt_o      (gnt),
        .ack_o      (ack),
        .full_i     (full),
        .w_en_o     (wEn),
        .data_in_o  (dataIn)
`ifdef FIFO_ARB_STATS_EN
        ,
        .wr_count_o    (wrCount),
        .stall_count_o (stallCount)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        reqData = '0;
        for (int i = 0; i < N; i++) begin
            reqData[i*W +: W] = prodData[i];
        end
    end

    // Return the first active requester at or after p, wrapping. Return -1 if none is active.
    function automatic int pickFrom(input int p);
        for (int i = 0; i < N; i++) begin
            if (req[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mCnt   = 0;
    endtask

    // Compute the outputs expected for the current owner and inputs.
    task automatic modelEval();
        expGnt  = '0;
        expAck  = '0;
        expWen  = 1'b0;
        expData = '0;
        if (mOwner >= 0) begin
            expGnt[mOwner] = 1'b1;
            if (req[mOwner] && !full) begin
                expWen  = 1'b1;
                expAck  = expGnt;
                expData = prodData[mOwner];
            end
        end
    endtask

    // Apply one clock edge to the model: accept the word, then end or continue the burst.
    task automatic modelAdvance();
        int  o;
        bit  endB;
        o    = mOwner;
        endB = 1'b0;
        if (expWen) begin
            prodData[o] = prodData[o] + 8'd1;
        end
        if (o < 0) begin
            mOwner = pickFrom(mPtr);
            mCnt   = 0;
        end else begin
            if (!req[o]) begin
                endB = 1'b1;
            end else if (expWen) begin
                mCnt = mCnt + 1;
                if (mCnt == MB) endB = 1'b1;
            end
            if (endB) begin
                mPtr   = (o + 1) % N;
                mCnt   = 0;
                mOwner = pickFrom(mPtr);
            end
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        dutLog.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        full  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack got=%b want=0000", ack); end
        checks++;
        if (wEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got=%b want=0", wEn); end
        checks++;
        if (dataIn !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h want=00", dataIn); end
        checks++;
        if (dut.ptr_q !== 2'd0 || dut.bcnt_q !== 3'd0 || dut.state_q !== fifo_arb_pkg::IDLE) begin
            errors++;
            $display("[TB] FAIL reset_state ptr=%0d bcnt=%0d state=%0d want 0/0/IDLE",
                     dut.ptr_q, dut.bcnt_q, dut.state_q);
        end
        checks++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req = 4'b0000;
        prodData[0] = 8'hA0;
        doReset();
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            modelEval();
            if (wEn) dutLog.push_back(dataIn);
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL single c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            if (c >= 1 && gnt !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL single_hold c=%0d gnt=%b want=0001", c, gnt);
            end
            if (c >= 1) checks++;
            @(posedge clk);
            #1;
            modelAdvance();
        end
        req = 4'b0000;
        if (dutLog.size() != 8) begin
            errors++;
            $display("[TB] FAIL single_count got=%0d want=8", dutLog.size());
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            if (dutLog[i] !== 8'(8'hA0 + i)) begin
                errors++;
                $display("[TB] FAIL single_order idx=%0d got=%h want=%h", i, dutLog[i], 8'(8'hA0 + i));
            end
            checks++;
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) prodData[i] = 8'(i * 16);
        req  = 4'b1111;
        full = 1'b0;
        doReset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            modelEval();
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL all_four c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            if (c >= 1) begin
                want = '0;
                want[((c - 1) / 4) % 4] = 1'b1;
                if (wEn !== 1'b1 || gnt !== want) begin
                    errors++;
                    $display("[TB] FAIL all_four_order c=%0d gnt=%b wen=%b want gnt=%b wen=1", c, gnt, wEn, want);
                end
                checks++;
            end
            @(posedge clk);
            #1;
            modelAdvance();
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic wantWen;
        req = 4'b0000;
        prodData[0] = 8'h50;
        doReset();
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            full = (c >= 3 && c <= 5);
            wantWen = (c == 1 || c == 2 || c == 6 || c == 7);
            @(negedge clk);
            modelEval();
            if (wEn) dutLog.push_back(dataIn);
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL backpressure c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            if (wEn !== wantWen) begin
                errors++;
                $display("[TB] FAIL backpressure_wen c=%0d got=%b want=%b", c, wEn, wantWen);
            end
            checks++;
            @(posedge clk);
            #1;
            modelAdvance();
        end
        full = 1'b0;
        if (dutLog.size() != 4 || dutLog[0] !== 8'h50 || dutLog[1] !== 8'h51 ||
            dutLog[2] !== 8'h52 || dutLog[3] !== 8'h53) begin
            errors++;
            $display("[TB] FAIL backpressure_words count=%0d got=%p want 50,51,52,53", dutLog.size(), dutLog);
        end
        checks++;
`ifdef FIFO_ARB_STATS_EN
        if (stallCount !== 16'd3) begin
            errors++;
            $display("[TB] FAIL stats_stall got=%0d want=3", stallCount);
        end
        checks++;
`endif
        req = 4'b0000;
    endtask

    task automatic test_early_release();
        req = 4'b0000;
        prodData[1] = 8'h11;
        prodData[2] = 8'h22;
        doReset();
        for (int c = 0; c < 5; c++) begin
            req = (c >= 2) ? 4'b0100 : 4'b0110;
            @(negedge clk);
            modelEval();
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL early c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            if (c == 2) begin
                if (wEn !== 1'b0 || gnt !== 4'b0010) begin
                    errors++;
                    $display("[TB] FAIL early_gap wen=%b gnt=%b want wen=0 gnt=0010", wEn, gnt);
                end
                checks++;
            end
            if (c == 3) begin
                if (gnt !== 4'b0100 || dut.ptr_q !== 2'd2 || wEn !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL early_handoff gnt=%b ptr=%0d wen=%b want 0100/2/1", gnt, dut.ptr_q, wEn);
                end
                checks++;
            end
            @(posedge clk);
            #1;
            modelAdvance();
        end
`ifdef FIFO_ARB_STATS_EN
        if (wrCount[1*16 +: 16] !== 16'd1 || stallCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL stats_early wr1=%0d stall=%0d want 1/0", wrCount[1*16 +: 16], stallCount);
        end
        checks++;
`endif
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        req = 4'b0000;
        prodData[0] = 8'h77;
        prodData[3] = 8'h33;
        doReset();
        req = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            modelEval();
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL async_pre c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            @(posedge clk);
            #1;
            modelAdvance();
        end
        #2;
        rst_n = 1'b0;
        #1;
        if (gnt !== 4'b0000 || wEn !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_drop gnt=%b wen=%b ack=%b want all 0", gnt, wEn, ack);
        end
        checks++;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        modelReset();
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            modelEval();
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL async_post c=%0d gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            if (c == 1) begin
                if (gnt !== 4'b1000 || dut.ptr_q !== 2'd0) begin
                    errors++;
                    $display("[TB] FAIL async_regrant gnt=%b ptr=%0d want 1000/0", gnt, dut.ptr_q);
                end
                checks++;
            end
            @(posedge clk);
            #1;
            modelAdvance();
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        req  = 4'b0000;
        full = 1'b0;
        for (int i = 0; i < N; i++) prodData[i] = 8'($urandom_range(0, 255));
        doReset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            full = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            modelEval();
            if ({gnt, ack, wEn, dataIn} !== {expGnt, expAck, expWen, expData}) begin
                errors++;
                $display("[TB] FAIL random c=%0d req=%b full=%b gnt=%b/%b ack=%b/%b wen=%b/%b data=%h/%h",
                         c, req, full, gnt, expGnt, ack, expAck, wEn, expWen, dataIn, expData);
            end
            checks++;
            @(posedge clk);
            #1;
            modelAdvance();
        end
        req  = 4'b0000;
        full = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        for (int i = 0; i < N; i++) prodData[i] = '0;
        modelReset();
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_early_release();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
